// File: rtl/control_seq_pkg.sv
// control_seq_pkg: shared types and field positions for the control sequencer.
//  Provides the opcode and FSM state enums, machineCode/instruction field positions,
//  the NOP control word, and a helper that builds the JF flag-select control word.
package control_seq_pkg;
    localparam int MC_W       = 14;
    localparam int INSTR_W    = 16;
    localparam int OP_MSB     = 15;
    localparam int OP_LSB     = 14;
    localparam int RADDR1_MSB = 12;
    localparam int RADDR1_LSB = 10;
    localparam logic [MC_W-1:0] NOP = '0;

    typedef enum logic [1:0] {OP_EXEC, OP_JMP, OP_JF, OP_HALT} opcode_t;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    // JF only presents raddr1 so the datapath can return the flag for that register.
    function automatic logic [MC_W-1:0] jf_word(input logic [INSTR_W-1:0] instr);
        return {1'b0, instr[RADDR1_MSB:RADDR1_LSB], 10'b0};
    endfunction
endpackage

// File: rtl/control_prog_mem.sv
// control_prog_mem: program store, DEPTH x 16, synchronous write, asynchronous read.
//  clk   in  clock
//  we    in  write strobe (already qualified by the caller)
//  waddr in  write address
//  wdata in  write data
//  raddr in  read address
//  rdata out combinational read data
module control_prog_mem #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [15:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [15:0]       rdata
);
    logic [15:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: runs a loadable program and issues one 14-bit control word per cycle.
//  Optional macro CU_SINGLE_STEP_EN adds a step input gating instruction execution.
//  clk         in  clock
//  reset       in  asynchronous active-high reset
//  start       in  run request, honoured in IDLE only
//  prog_we     in  program write strobe, dropped while busy
//  prog_addr   in  program write address
//  prog_data   in  instruction word
//  cond_flag   in  datapath flag for the JF instruction
//  step        in  (CU_SINGLE_STEP_EN only) execute the current instruction this cycle
//  machineCode out control word to datapath
//  busy        out high in RUN
//  done        out one-cycle pulse after HALT
//  retired     out saturating count of EXEC words issued this run
module control_sequencer
    import control_seq_pkg::*;
#(
    parameter  int PROG_DEPTH = 16,
    parameter  int CNT_W      = 16,
    localparam int ADDR_W     = $clog2(PROG_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [15:0]       prog_data,
    input  logic              cond_flag,
`ifdef CU_SINGLE_STEP_EN
    input  logic              step,
`endif
    output logic [MC_W-1:0]   machineCode,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  retired
);
    state_t             state, state_next;
    logic [ADDR_W-1:0]  pc, pc_next, pc_inc;
    logic [CNT_W-1:0]   retired_next;
    logic [15:0]        instr;
    logic               advance;
    opcode_t            op;

    control_prog_mem #(.DEPTH(PROG_DEPTH), .ADDR_W(ADDR_W)) u_mem (
        .clk   (clk),
        .we    (prog_we && !busy),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (pc),
        .rdata (instr)
    );

    assign busy   = (state == S_RUN);
    assign done   = (state == S_DONE);
    assign op     = opcode_t'(instr[OP_MSB:OP_LSB]);
    assign pc_inc = pc + ADDR_W'(1);
`ifdef CU_SINGLE_STEP_EN
    assign advance = step;
`else
    assign advance = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state   <= S_IDLE;
            pc      <= '0;
            retired <= '0;
        end else begin
            state   <= state_next;
            pc      <= pc_next;
            retired <= retired_next;
        end

    always_comb begin
        state_next   = state;
        pc_next      = pc;
        retired_next = retired;
        machineCode  = NOP;
        case (state)
            S_IDLE: if (start) begin
                state_next   = S_RUN;
                pc_next      = '0;
                retired_next = '0;
            end
            S_RUN: if (advance)
                case (op)
                    OP_EXEC: begin
                        machineCode  = instr[MC_W-1:0];
                        pc_next      = pc_inc;
                        retired_next = &retired ? retired : retired + CNT_W'(1);
                    end
                    OP_JMP: pc_next = instr[ADDR_W-1:0];
                    OP_JF: begin
                        machineCode = jf_word(instr);
                        pc_next     = cond_flag ? instr[ADDR_W-1:0] : pc_inc;
                    end
                    default: state_next = S_DONE;
                endcase
            default: state_next = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: table-driven, scoreboard-checked bench for control_sequencer.
module tb_control_sequencer;
    logic        clk = 0, reset = 1, start = 0, prog_we = 0, cond_flag = 0, step = 1;
    logic [3:0]  prog_addr = 0;
    logic [15:0] prog_data = 0;
    logic [13:0] mc, mc_s;
    logic        busy, done, busy_s, done_s;
    logic [15:0] retired;
    logic [2:0]  retired_s;

    always #5 clk = ~clk;

    control_sequencer #(.PROG_DEPTH(16), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .cond_flag(cond_flag),
`ifdef CU_SINGLE_STEP_EN
        .step(step),
`endif
        .machineCode(mc), .busy(busy), .done(done), .retired(retired)
    );

    control_sequencer #(.PROG_DEPTH(4), .CNT_W(3)) dut_s (
        .clk(clk), .reset(reset), .start(start), .prog_we(prog_we), .prog_addr(prog_addr[1:0]),
        .prog_data(prog_data), .cond_flag(cond_flag),
`ifdef CU_SINGLE_STEP_EN
        .step(step),
`endif
        .machineCode(mc_s), .busy(busy_s), .done(done_s), .retired(retired_s)
    );

    typedef struct {
        logic        start, cond, we;
        logic [3:0]  addr;
        logic [15:0] data;
        logic [13:0] mc;
        logic        busy, done;
        logic [15:0] ret;
    } vec_t;
    typedef struct {
        logic [13:0] mc;
        logic        busy, done;
        logic [15:0] ret;
    } exp_t;

    vec_t  tbl[$];
    exp_t  sb[$];
    int    errors = 0, checks = 0;
    string tag;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] a, input logic [15:0] d);
        prog_we = 1; prog_addr = a; prog_data = d;
        tick();
        prog_we = 0;
    endtask

    function automatic void add(input logic s, input logic c, input logic [13:0] m,
                                input logic b, input logic dn, input logic [15:0] r);
        tbl.push_back('{s, c, 1'b0, 4'd0, 16'd0, m, b, dn, r});
    endfunction

    function automatic void addw(input logic s, input logic [3:0] a, input logic [15:0] d,
                                 input logic [13:0] m, input logic b, input logic dn,
                                 input logic [15:0] r);
        tbl.push_back('{s, 1'b0, 1'b1, a, d, m, b, dn, r});
    endfunction

    task automatic apply;
        exp_t e;
        for (int i = 0; i < tbl.size(); i++) begin
            start = tbl[i].start; cond_flag = tbl[i].cond; prog_we = tbl[i].we;
            prog_addr = tbl[i].addr; prog_data = tbl[i].data;
            sb.push_back('{tbl[i].mc, tbl[i].busy, tbl[i].done, tbl[i].ret});
            #2;
            e = sb.pop_front();
            check($sformatf("%s[%0d] machineCode", tag, i), mc, e.mc);
            check($sformatf("%s[%0d] busy", tag, i), busy, e.busy);
            check($sformatf("%s[%0d] done", tag, i), done, e.done);
            check($sformatf("%s[%0d] retired", tag, i), retired, e.ret);
            tick();
        end
        start = 0; cond_flag = 0; prog_we = 0;
        tbl.delete();
    endtask

    initial begin
        exp_t e;
        int   pc_m, r;
        tick(); tick();
        reset = 0;
        #2;
        check("reset machineCode", mc, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset retired", retired, 0);
        tick();

        tag = "exec_halt";
        load(0, 16'h2018); load(1, 16'hC000);
        add(1, 0, 14'h0, 0, 0, 0);
        add(0, 0, 14'h2018, 1, 0, 0);
        add(0, 0, 14'h0, 1, 0, 1);
        add(0, 0, 14'h0, 0, 1, 1);
        add(0, 0, 14'h0, 0, 0, 1);
        apply();

        tag = "jmp";
        load(0, 16'h4002); load(1, 16'h2018); load(2, 16'hC000);
        add(1, 0, 14'h0, 0, 0, 1);
        add(0, 0, 14'h0, 1, 0, 0);
        add(0, 0, 14'h0, 1, 0, 0);
        add(0, 0, 14'h0, 0, 1, 0);
        add(0, 0, 14'h0, 0, 0, 0);
        apply();

        tag = "jf";
        load(0, 16'h8403); load(1, 16'h2001); load(2, 16'hC000); load(3, 16'h2003);
        load(4, 16'hC000);
        add(1, 0, 14'h0, 0, 0, 0);
        add(0, 1, 14'h0400, 1, 0, 0);
        add(0, 0, 14'h2003, 1, 0, 0);
        add(0, 0, 14'h0, 1, 0, 1);
        add(0, 0, 14'h0, 0, 1, 1);
        add(1, 0, 14'h0, 0, 0, 1);
        add(0, 0, 14'h0400, 1, 0, 0);
        add(0, 0, 14'h2001, 1, 0, 0);
        add(0, 0, 14'h0, 1, 0, 1);
        add(0, 0, 14'h0, 0, 1, 1);
        apply();

        tag = "reset_mid";
        load(0, 16'h2001); load(1, 16'h2002); load(2, 16'h2003); load(3, 16'hC000);
        add(1, 0, 14'h0, 0, 0, 1);
        add(0, 0, 14'h2001, 1, 0, 0);
        add(0, 0, 14'h2002, 1, 0, 1);
        apply();
        #2;
        check("reset_mid pc2 machineCode", mc, 14'h2003);
        check("reset_mid pc2 retired", retired, 2);
        reset = 1;
        #1;
        check("reset_mid busy", busy, 0);
        check("reset_mid machineCode", mc, 0);
        check("reset_mid retired", retired, 0);
        check("reset_mid done", done, 0);
        tick();
        reset = 0;
        tag = "restart";
        add(1, 0, 14'h0, 0, 0, 0);
        add(0, 0, 14'h2001, 1, 0, 0);
        add(0, 0, 14'h2002, 1, 0, 1);
        add(0, 0, 14'h2003, 1, 0, 2);
        add(0, 0, 14'h0, 1, 0, 3);
        add(0, 0, 14'h0, 0, 1, 3);
        apply();

        tag = "busy_ignore";
        add(1, 0, 14'h0, 0, 0, 3);
        add(0, 0, 14'h2001, 1, 0, 0);
        addw(1, 1, 16'h2777, 14'h2002, 1, 0, 1);
        add(0, 0, 14'h2003, 1, 0, 2);
        add(0, 0, 14'h0, 1, 0, 3);
        add(1, 0, 14'h0, 0, 1, 3);
        add(0, 0, 14'h0, 0, 0, 3);
        addw(1, 0, 16'h2555, 14'h0, 0, 0, 3);
        add(0, 0, 14'h2555, 1, 0, 0);
        add(0, 0, 14'h2002, 1, 0, 1);
        add(0, 0, 14'h2003, 1, 0, 2);
        add(0, 0, 14'h0, 1, 0, 3);
        add(0, 0, 14'h0, 0, 1, 3);
        apply();

        reset = 1;
        tick();
        reset = 0;
        #1;
        check("small reset machineCode", mc_s, 0);
        check("small reset busy", busy_s, 0);
        check("small reset retired", retired_s, 0);
        tick();
        for (int i = 0; i < 4; i++) load(4'(i), 16'(i + 1));
        start = 1;
        tick();
        start = 0;
        pc_m = 0;
        r = 0;
        for (int i = 0; i < 14; i++) begin
`ifdef CU_SINGLE_STEP_EN
            step = !(i >= 3 && i < 8);
`endif
            sb.push_back('{step ? 14'(pc_m + 1) : 14'h0, 1'b1, 1'b0, 16'(r)});
            #2;
            e = sb.pop_front();
            check($sformatf("wrap[%0d] machineCode", i), mc_s, e.mc);
            check($sformatf("wrap[%0d] busy", i), busy_s, e.busy);
            check($sformatf("wrap[%0d] retired", i), retired_s, e.ret);
            if (step) begin
                pc_m = (pc_m + 1) % 4;
                if (r < 7) r++;
            end
            tick();
        end
        step = 1;
        reset = 1;
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
